pec_flow_ctrl: RTL and testbench

- Parametrised control core for a PE cluster: weight-config handshake, activation capture and forwarding chain, MAC start/finish sequencing, and partial-sum RAM address generation.
- Successor to the fixed 3x3 PE cluster controller. Generalised in MAC count, channel depth and psum depth.
- Adds three behaviours: a backpressure-safe forward buffer, first-block psum initialisation that skips the RAM read, and a configurable address wrap.
- Sits between the upstream PE cluster (or activation buffer), the downstream PE cluster, the MAC array and the psum SRAM.

---
 rtl/pec_flow_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_pec_flow_ctrl.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pec_flow_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pec_flow_ctrl
// Description : Control core for a PE cluster. It handles the weight-config
//               handshake and captures activations into a forward buffer that
//               is safe under downstream backpressure. It also sequences the
//               MAC start/finish and generates wrapping psum RAM addresses,
//               including the psum-init row clear.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
module pec_flow_ctrl #(
  parameter int DATA_WIDTH    = 8,
  parameter int CHANNEL_DEPTH = 32,
  parameter int NUM_MAC       = 9,
  parameter int PSUM_ROWS     = 16,
  localparam int AW           = (PSUM_ROWS > 1) ? $clog2(PSUM_ROWS) : 1
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                wei_rdy,
  output logic                                wei_get,
  input  logic                                lst_act_rdy,
  output logic                                lst_act_get,
  input  logic                                lst_frt_row,
  input  logic                                lst_lst_row,
  input  logic                                lst_lst_blk,
  input  logic                                lst_psum_init,
  input  logic [CHANNEL_DEPTH-1:0]            act_flg,
  input  logic [DATA_WIDTH*CHANNEL_DEPTH-1:0] act,
  output logic [CHANNEL_DEPTH-1:0]            mac_act_flg,
  output logic [DATA_WIDTH*CHANNEL_DEPTH-1:0] mac_act,
  output logic                                nxt_frt_row,
  output logic                                nxt_lst_row,
  output logic                                nxt_lst_blk,
  output logic                                nxt_psum_init,
  output logic                                nxt_act_rdy,
  input  logic                                nxt_act_get,
  output logic                                mac_sta,
  input  logic [NUM_MAC-1:0]                  mac_fnh,
  output logic                                psum_clr,
  output logic                                ram_en_rd,
  output logic [AW-1:0]                       ram_addr_rd,
  output logic                                ram_en_wr,
  output logic [AW-1:0]                       ram_addr_wr,
  output logic                                busy
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CFGWEI  = 2'd1,
    S_WAITACT = 2'd2,
    S_RUN     = 2'd3
  } state_t;

  localparam logic [AW-1:0] c_last_row = AW'(PSUM_ROWS - 1);

  state_t                          r_state;
  state_t                          w_state_nxt;
  logic                            w_wei_get;
  logic                            w_cap;
  logic                            w_done;

  logic [DATA_WIDTH*CHANNEL_DEPTH-1:0] r_mac_act;
  logic [CHANNEL_DEPTH-1:0]        r_mac_act_flg;
  logic                            r_frt_row;
  logic                            r_lst_row;
  logic                            r_lst_blk;
  logic                            r_psum_init;
  logic                            r_nxt_vld;
  logic                            r_mac_sta;
  logic                            r_psum_clr;
  logic                            r_busy;
  logic [AW-1:0]                   r_addr_rd;
  logic [AW-1:0]                   r_addr_wr;

  // Row address advance with wrap from the last row back to zero
  function automatic logic [AW-1:0] f_next_addr(input logic [AW-1:0] a);
    return (a == c_last_row) ? '0 : a + 1'b1;
  endfunction

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state decode plus the capture / done / weight handshake strobes
  always_comb begin
    w_state_nxt = r_state;
    w_wei_get   = 1'b0;
    w_cap       = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_state_nxt = S_CFGWEI;
      end
      S_CFGWEI: begin
        w_wei_get = wei_rdy;
        if (wei_rdy) w_state_nxt = S_WAITACT;
      end
      S_WAITACT: begin
        // A new activation may only overwrite the buffer once downstream has
        // taken (or is taking this cycle) the previous one.
        w_cap = lst_act_rdy && (!r_nxt_vld || nxt_act_get);
        if (w_cap) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        // Finish flags are still stale from the previous job in the start cycle
        w_done = (&mac_fnh) && !r_mac_sta;
        if (w_done) w_state_nxt = r_lst_blk ? S_CFGWEI : S_WAITACT;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Activation and tag capture; held stable until the next capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mac_act     <= '0;
      r_mac_act_flg <= '0;
      r_frt_row     <= 1'b0;
      r_lst_row     <= 1'b0;
      r_lst_blk     <= 1'b0;
      r_psum_init   <= 1'b0;
    end else if (w_cap) begin
      r_mac_act     <= act;
      r_mac_act_flg <= act_flg;
      r_frt_row     <= lst_frt_row;
      r_lst_row     <= lst_lst_row;
      r_lst_blk     <= lst_lst_blk;
      r_psum_init   <= lst_psum_init;
    end
  end

  // Forward-buffer valid, MAC start pulse, psum clear window and busy flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_nxt_vld  <= 1'b0;
      r_mac_sta  <= 1'b0;
      r_psum_clr <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_mac_sta <= w_cap;
      if (w_cap)            r_nxt_vld <= 1'b1;
      else if (nxt_act_get) r_nxt_vld <= 1'b0;
      if (w_cap)       r_psum_clr <= lst_frt_row && lst_psum_init;
      else if (w_done) r_psum_clr <= 1'b0;
      // Derived from the next state so it is low straight out of reset
      r_busy <= (w_state_nxt != S_CFGWEI);
    end
  end

  // Psum read/write row pointers; end of block rewinds both
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr_rd <= '0;
      r_addr_wr <= '0;
    end else if (w_done && r_lst_blk) begin
      r_addr_rd <= '0;
      r_addr_wr <= '0;
    end else begin
      if (w_cap && lst_frt_row) r_addr_rd <= f_next_addr(r_addr_rd);
      if (w_done && r_lst_row)  r_addr_wr <= f_next_addr(r_addr_wr);
    end
  end

  assign wei_get       = w_wei_get;
  assign lst_act_get   = w_cap;
  assign mac_act       = r_mac_act;
  assign mac_act_flg   = r_mac_act_flg;
  assign nxt_frt_row   = r_frt_row;
  assign nxt_lst_row   = r_lst_row;
  assign nxt_lst_blk   = r_lst_blk;
  assign nxt_psum_init = r_psum_init;
  assign nxt_act_rdy   = r_nxt_vld;
  assign mac_sta       = r_mac_sta;
  assign psum_clr      = r_psum_clr;
  assign ram_en_rd     = w_cap && lst_frt_row && !lst_psum_init;
  assign ram_addr_rd   = r_addr_rd;
  assign ram_en_wr     = w_done && r_lst_row;
  assign ram_addr_wr   = r_addr_wr;
  assign busy          = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_pec_flow_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pec_flow_ctrl
// Description : Self-checking bench for pec_flow_ctrl with a transaction-level
//               reference model (row pointers, buffer occupancy, held data).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pec_flow_ctrl;

  localparam int DW = 8;
  localparam int CD = 4;
  localparam int NM = 3;
  localparam int PR = 4;
  localparam int AW = (PR > 1) ? $clog2(PR) : 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              wei_rdy = 1'b0;
  logic              wei_get;
  logic              lst_act_rdy = 1'b0;
  logic              lst_act_get;
  logic              lst_frt_row = 1'b0;
  logic              lst_lst_row = 1'b0;
  logic              lst_lst_blk = 1'b0;
  logic              lst_psum_init = 1'b0;
  logic [CD-1:0]     act_flg = '0;
  logic [DW*CD-1:0]  act = '0;
  logic [CD-1:0]     mac_act_flg;
  logic [DW*CD-1:0]  mac_act;
  logic              nxt_frt_row, nxt_lst_row, nxt_lst_blk, nxt_psum_init;
  logic              nxt_act_rdy;
  logic              nxt_act_get = 1'b0;
  logic              mac_sta;
  logic [NM-1:0]     mac_fnh = '0;
  logic              psum_clr;
  logic              ram_en_rd;
  logic [AW-1:0]     ram_addr_rd;
  logic              ram_en_wr;
  logic [AW-1:0]     ram_addr_wr;
  logic              busy;

  always #5 clk = ~clk;

  pec_flow_ctrl #(
    .DATA_WIDTH(DW), .CHANNEL_DEPTH(CD), .NUM_MAC(NM), .PSUM_ROWS(PR)
  ) dut (
    .clk(clk), .rst_n(rst_n), .wei_rdy(wei_rdy), .wei_get(wei_get),
    .lst_act_rdy(lst_act_rdy), .lst_act_get(lst_act_get),
    .lst_frt_row(lst_frt_row), .lst_lst_row(lst_lst_row),
    .lst_lst_blk(lst_lst_blk), .lst_psum_init(lst_psum_init),
    .act_flg(act_flg), .act(act), .mac_act_flg(mac_act_flg), .mac_act(mac_act),
    .nxt_frt_row(nxt_frt_row), .nxt_lst_row(nxt_lst_row),
    .nxt_lst_blk(nxt_lst_blk), .nxt_psum_init(nxt_psum_init),
    .nxt_act_rdy(nxt_act_rdy), .nxt_act_get(nxt_act_get),
    .mac_sta(mac_sta), .mac_fnh(mac_fnh), .psum_clr(psum_clr),
    .ram_en_rd(ram_en_rd), .ram_addr_rd(ram_addr_rd),
    .ram_en_wr(ram_en_wr), .ram_addr_wr(ram_addr_wr), .busy(busy)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: row pointers, forward-buffer occupancy, held data
  int               m_rd, m_wr;
  bit               m_vld, m_cfg;
  logic [DW*CD-1:0] m_act;
  logic [CD-1:0]    m_flg;

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0; wei_rdy = 1'b0; lst_act_rdy = 1'b1; nxt_act_get = 1'b0; mac_fnh = '1;
    #1;
    n_vec++; if ({busy, nxt_act_rdy, mac_sta, psum_clr, ram_en_rd, ram_en_wr, lst_act_get, wei_get} !== 8'h00) begin
      n_err++; $display("FAIL rst_ctrl: got %b exp 00000000", {busy, nxt_act_rdy, mac_sta, psum_clr, ram_en_rd, ram_en_wr, lst_act_get, wei_get}); end
    n_vec++; if ({ram_addr_rd, ram_addr_wr} !== '0) begin
      n_err++; $display("FAIL rst_addr: got rd=%0d wr=%0d exp 0/0", ram_addr_rd, ram_addr_wr); end
    n_vec++; if ({mac_act, mac_act_flg, nxt_frt_row, nxt_lst_row, nxt_lst_blk, nxt_psum_init} !== '0) begin
      n_err++; $display("FAIL rst_data: got act=%h flg=%h exp 0", mac_act, mac_act_flg); end
    lst_act_rdy = 1'b0; mac_fnh = '0;
    m_rd = 0; m_wr = 0; m_vld = 0; m_act = '0; m_flg = '0; m_cfg = 1;
    @(negedge clk);
    rst_n = 1'b1; wei_rdy = 1'b1;
    #1;
    n_vec++; if (wei_get !== 1'b0 || busy !== 1'b0) begin
      n_err++; $display("FAIL idle_cycle: got wei_get=%b busy=%b exp 0/0", wei_get, busy); end
  endtask

  task automatic do_cfg(input int waits);
    for (int i = 0; i < waits; i++) begin
      @(negedge clk);
      wei_rdy = 1'b0; lst_act_rdy = 1'b1; lst_frt_row = 1'b1; nxt_act_get = 1'b0;
      #1;
      n_vec++; if (wei_get !== 1'b0 || lst_act_get !== 1'b0 || busy !== 1'b0 || nxt_act_rdy !== m_vld) begin
        n_err++; $display("FAIL cfg_wait: got wei_get=%b act_get=%b busy=%b rdy=%b exp 0/0/0/%b",
                          wei_get, lst_act_get, busy, nxt_act_rdy, m_vld); end
    end
    @(negedge clk);
    wei_rdy = 1'b1; lst_act_rdy = 1'b1;
    #1;
    n_vec++; if (wei_get !== 1'b1 || lst_act_get !== 1'b0 || busy !== 1'b0) begin
      n_err++; $display("FAIL cfg_accept: got wei_get=%b act_get=%b busy=%b exp 1/0/0", wei_get, lst_act_get, busy); end
    @(negedge clk);
    wei_rdy = 1'b0; lst_act_rdy = 1'b0;
    #1;
    n_vec++; if (wei_get !== 1'b0 || busy !== 1'b1 || ram_addr_rd !== AW'(m_rd) || ram_addr_wr !== AW'(m_wr)) begin
      n_err++; $display("FAIL cfg_after: got wei_get=%b busy=%b rd=%0d wr=%0d exp 0/1/%0d/%0d",
                        wei_get, busy, ram_addr_rd, ram_addr_wr, m_rd, m_wr); end
    m_cfg = 0;
  endtask

  // One activation end to end: optional downstream hold, capture, MAC run, done
  task automatic send_act(input bit frt, input bit lst, input bit blk, input bit init,
                          input int dly, input bit hold, input bit consume);
    logic [DW*CD-1:0] d_act;
    logic [CD-1:0]    d_flg;
    logic [NM-1:0]    fnh;
    bit               e_clr;
    for (int i = 0; i < CD; i++) d_act[i*DW +: DW] = DW'($urandom);
    d_flg = CD'($urandom);
    e_clr = frt && init;
    if (hold && m_vld) begin
      for (int i = 0; i < 2; i++) begin
        @(negedge clk);
        lst_act_rdy = 1'b1; lst_frt_row = frt; lst_lst_row = lst; lst_lst_blk = blk; lst_psum_init = init;
        act = d_act; act_flg = d_flg; nxt_act_get = 1'b0; mac_fnh = '1;
        #1;
        n_vec++; if (lst_act_get !== 1'b0 || nxt_act_rdy !== 1'b1) begin
          n_err++; $display("FAIL hold_nocap: got act_get=%b rdy=%b exp 0/1", lst_act_get, nxt_act_rdy); end
        n_vec++; if (mac_act !== m_act || mac_act_flg !== m_flg) begin
          n_err++; $display("FAIL hold_data: got %h/%h exp %h/%h", mac_act, mac_act_flg, m_act, m_flg); end
      end
    end
    @(negedge clk);
    lst_act_rdy = 1'b1; lst_frt_row = frt; lst_lst_row = lst; lst_lst_blk = blk; lst_psum_init = init;
    act = d_act; act_flg = d_flg; mac_fnh = '1;
    nxt_act_get = m_vld ? 1'b1 : 1'(($urandom % 2));
    #1;
    n_vec++; if (lst_act_get !== 1'b1 || nxt_act_rdy !== m_vld) begin
      n_err++; $display("FAIL cap: got act_get=%b rdy=%b exp 1/%b", lst_act_get, nxt_act_rdy, m_vld); end
    n_vec++; if (ram_en_rd !== (frt && !init) || ram_addr_rd !== AW'(m_rd)) begin
      n_err++; $display("FAIL cap_rd: got en=%b addr=%0d exp %b/%0d", ram_en_rd, ram_addr_rd, frt && !init, m_rd); end
    m_vld = 1; m_act = d_act; m_flg = d_flg;
    if (frt) m_rd = (m_rd + 1) % PR;
    // MAC start cycle: finish flags still high from the previous job
    @(negedge clk);
    lst_act_rdy = 1'b0; act = ~d_act; act_flg = ~d_flg; nxt_act_get = 1'b0; mac_fnh = '1;
    #1;
    n_vec++; if (mac_sta !== 1'b1 || ram_en_wr !== 1'b0 || busy !== 1'b1) begin
      n_err++; $display("FAIL sta: got sta=%b en_wr=%b busy=%b exp 1/0/1", mac_sta, ram_en_wr, busy); end
    n_vec++; if (mac_act !== m_act || mac_act_flg !== m_flg ||
                 {nxt_frt_row, nxt_lst_row, nxt_lst_blk, nxt_psum_init} !== {frt, lst, blk, init}) begin
      n_err++; $display("FAIL sta_data: got %h/%h tags=%b exp %h/%h tags=%b", mac_act, mac_act_flg,
                        {nxt_frt_row, nxt_lst_row, nxt_lst_blk, nxt_psum_init}, m_act, m_flg, {frt, lst, blk, init}); end
    n_vec++; if (psum_clr !== e_clr || ram_addr_rd !== AW'(m_rd) || nxt_act_rdy !== 1'b1) begin
      n_err++; $display("FAIL sta_misc: got clr=%b rd=%0d rdy=%b exp %b/%0d/1", psum_clr, ram_addr_rd, nxt_act_rdy, e_clr, m_rd); end
    for (int i = 0; i < dly; i++) begin
      @(negedge clk);
      fnh = NM'($urandom);
      fnh[$urandom % NM] = 1'b0;
      mac_fnh = fnh; lst_act_rdy = 1'($urandom % 2);
      nxt_act_get = consume ? 1'($urandom % 2) : 1'b0;
      #1;
      n_vec++; if (lst_act_get !== 1'b0 || mac_sta !== 1'b0 || ram_en_wr !== 1'b0 || psum_clr !== e_clr || nxt_act_rdy !== m_vld) begin
        n_err++; $display("FAIL run: got get=%b sta=%b wr=%b clr=%b rdy=%b exp 0/0/0/%b/%b",
                          lst_act_get, mac_sta, ram_en_wr, psum_clr, nxt_act_rdy, e_clr, m_vld); end
      if (nxt_act_get) m_vld = 0;
    end
    @(negedge clk);
    lst_act_rdy = 1'b0; mac_fnh = '1;
    nxt_act_get = consume ? 1'($urandom % 2) : 1'b0;
    #1;
    n_vec++; if (ram_en_wr !== lst || ram_addr_wr !== AW'(m_wr) || psum_clr !== e_clr || nxt_act_rdy !== m_vld) begin
      n_err++; $display("FAIL done: got wr=%b addr=%0d clr=%b rdy=%b exp %b/%0d/%b/%b",
                        ram_en_wr, ram_addr_wr, psum_clr, nxt_act_rdy, lst, m_wr, e_clr, m_vld); end
    if (nxt_act_get) m_vld = 0;
    if (blk) begin m_rd = 0; m_wr = 0; m_cfg = 1; end
    else if (lst) m_wr = (m_wr + 1) % PR;
    @(negedge clk);
    lst_act_rdy = 1'b0; nxt_act_get = 1'b0; mac_fnh = '0;
    #1;
    n_vec++; if (ram_addr_rd !== AW'(m_rd) || ram_addr_wr !== AW'(m_wr) || busy !== !blk ||
                 psum_clr !== 1'b0 || ram_en_wr !== 1'b0 || nxt_act_rdy !== m_vld) begin
      n_err++; $display("FAIL after: got rd=%0d wr=%0d busy=%b clr=%b en_wr=%b rdy=%b exp %0d/%0d/%b/0/0/%b",
                        ram_addr_rd, ram_addr_wr, busy, psum_clr, ram_en_wr, nxt_act_rdy, m_rd, m_wr, !blk, m_vld); end
  endtask

  task automatic test_reset();
    apply_reset();
    do_cfg(2);
  endtask

  task automatic test_psum_read();
    send_act(1'b1, 1'b0, 1'b0, 1'b0, 3, 1'b0, 1'b0);
    n_vec++; if (ram_addr_rd !== AW'(1)) begin
      n_err++; $display("FAIL read_incr: got %0d exp 1", ram_addr_rd); end
  endtask

  task automatic test_backpressure();
    send_act(1'b0, 1'b0, 1'b0, 1'b0, 1, 1'b1, 1'b0);
  endtask

  task automatic test_psum_clear();
    send_act(1'b1, 1'b0, 1'b0, 1'b1, 2, 1'b0, 1'b1);
    n_vec++; if (ram_addr_rd !== AW'(2)) begin
      n_err++; $display("FAIL clr_incr: got %0d exp 2", ram_addr_rd); end
  endtask

  task automatic test_last_block();
    send_act(1'b0, 1'b1, 1'b0, 1'b0, 1, 1'b0, 1'b1);
    send_act(1'b0, 1'b1, 1'b1, 1'b0, 2, 1'b0, 1'b1);
    n_vec++; if (ram_addr_rd !== '0 || ram_addr_wr !== '0 || busy !== 1'b0) begin
      n_err++; $display("FAIL blk_rewind: got rd=%0d wr=%0d busy=%b exp 0/0/0", ram_addr_rd, ram_addr_wr, busy); end
    do_cfg(1);
  endtask

  task automatic test_wrap();
    int exp_wr[5] = '{1, 2, 3, 0, 1};
    apply_reset();
    do_cfg(0);
    for (int i = 0; i < 5; i++) begin
      send_act(1'b1, 1'b1, 1'b0, 1'b0, i % 3, 1'b0, 1'b1);
      n_vec++; if (ram_addr_wr !== AW'(exp_wr[i])) begin
        n_err++; $display("FAIL wrap_%0d: got %0d exp %0d", i, ram_addr_wr, exp_wr[i]); end
    end
  endtask

  task automatic test_mid_reset();
    @(negedge clk);
    lst_act_rdy = 1'b1; lst_frt_row = 1'b1; lst_psum_init = 1'b0; nxt_act_get = 1'b1;
    act = '1; act_flg = '1;
    #1;
    n_vec++; if (lst_act_get !== 1'b1) begin
      n_err++; $display("FAIL mid_cap: got %b exp 1", lst_act_get); end
    apply_reset();
    do_cfg(1);
  endtask

  task automatic test_random();
    for (int k = 0; k < 24; k++) begin
      if (m_cfg) do_cfg($urandom % 3);
      send_act(1'($urandom % 2), 1'($urandom % 2), 1'(($urandom % 4) == 0), 1'($urandom % 2),
               $urandom % 5, 1'($urandom % 2), 1'($urandom % 2));
    end
  endtask

  initial begin
    test_reset();
    test_psum_read();
    test_backpressure();
    test_psum_clear();
    test_last_block();
    test_wrap();
    test_mid_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
